// File: rtl/unified_cache_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// unified_cache_port_arbiter_if
// Bundles the requester-side and cache-side packet handshakes of the unified
// cache port arbiter.
//   request_packet_flatted_in      : N packets from requesters, slot i at [i*W +: W]
//   request_packet_ack_flatted_out : one-cycle accept pulse per requester
//   cache_packet_out               : packet presented to the cache
//   cache_packet_ack_in            : cache accepted cache_packet_out
//   cache_return_packet_in         : return packet from the cache
//   cache_return_packet_ack_out    : return packet accepted
//   return_packet_flatted_out      : return packet steered to its owner slot
//   return_packet_ack_flatted_in   : requester accepted its return packet
//   error_out                      : sticky error flag
// Modport slave is the arbiter side, master is the surrounding environment.
// -----------------------------------------------------------------------------
`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS 16
`endif
`ifndef UNIFIED_CACHE_PACKET_PORT_ID_WIDTH
`define UNIFIED_CACHE_PACKET_PORT_ID_WIDTH 3
`endif
`ifndef UNIFIED_CACHE_PACKET_VALID_POS
`define UNIFIED_CACHE_PACKET_VALID_POS 0
`endif
`ifndef UNIFIED_CACHE_PACKET_PORT_NUM_LO
`define UNIFIED_CACHE_PACKET_PORT_NUM_LO 1
`endif

interface unified_cache_port_arbiter_if #(
  parameter int NUM_REQUESTER = 4,
  parameter int PACKET_WIDTH  = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
);
  logic [NUM_REQUESTER*PACKET_WIDTH-1:0] request_packet_flatted_in;
  logic [NUM_REQUESTER-1:0]              request_packet_ack_flatted_out;
  logic [PACKET_WIDTH-1:0]               cache_packet_out;
  logic                                  cache_packet_ack_in;
  logic [PACKET_WIDTH-1:0]               cache_return_packet_in;
  logic                                  cache_return_packet_ack_out;
  logic [NUM_REQUESTER*PACKET_WIDTH-1:0] return_packet_flatted_out;
  logic [NUM_REQUESTER-1:0]              return_packet_ack_flatted_in;
  logic                                  error_out;

  modport slave (
    input  request_packet_flatted_in,
    input  cache_packet_ack_in,
    input  cache_return_packet_in,
    input  return_packet_ack_flatted_in,
    output request_packet_ack_flatted_out,
    output cache_packet_out,
    output cache_return_packet_ack_out,
    output return_packet_flatted_out,
    output error_out
  );

  modport master (
    output request_packet_flatted_in,
    output cache_packet_ack_in,
    output cache_return_packet_in,
    output return_packet_ack_flatted_in,
    input  request_packet_ack_flatted_out,
    input  cache_packet_out,
    input  cache_return_packet_ack_out,
    input  return_packet_flatted_out,
    input  error_out
  );
endinterface

// File: rtl/unified_cache_port_arbiter.sv
// -----------------------------------------------------------------------------
// unified_cache_port_arbiter
// Round-robin arbiter sharing one unified-cache request port among
// NUM_REQUESTER packet sources. The winner's packet is registered onto the
// cache port with its port-number field replaced by the winner index; return
// packets are steered combinationally back to the owner named in that field.
//   clk_in   : clock, all state on the rising edge
//   reset_in : asynchronous active-low reset
//   io_bus   : packet handshakes (see unified_cache_port_arbiter_if)
// -----------------------------------------------------------------------------
`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS 16
`endif
`ifndef UNIFIED_CACHE_PACKET_PORT_ID_WIDTH
`define UNIFIED_CACHE_PACKET_PORT_ID_WIDTH 3
`endif
`ifndef UNIFIED_CACHE_PACKET_VALID_POS
`define UNIFIED_CACHE_PACKET_VALID_POS 0
`endif
`ifndef UNIFIED_CACHE_PACKET_PORT_NUM_LO
`define UNIFIED_CACHE_PACKET_PORT_NUM_LO 1
`endif

module unified_cache_port_arbiter #(
  parameter int NUM_REQUESTER                      = 4,
  parameter int TIMING_OUT_CYCLE                   = 100000,
  parameter int UNIFIED_CACHE_PACKET_WIDTH_IN_BITS = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS,
  parameter int UNIFIED_CACHE_PACKET_PORT_ID_WIDTH = `UNIFIED_CACHE_PACKET_PORT_ID_WIDTH
) (
  input  logic                            clk_in,
  input  logic                            reset_in,
  unified_cache_port_arbiter_if.slave     io_bus
);

  localparam int W    = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
  localparam int P    = UNIFIED_CACHE_PACKET_PORT_ID_WIDTH;
  localparam int VP   = `UNIFIED_CACHE_PACKET_VALID_POS;
  localparam int PLO  = `UNIFIED_CACHE_PACKET_PORT_NUM_LO;
  localparam int PHI  = PLO + P - 1;
  localparam int IDXW = (NUM_REQUESTER > 1) ? $clog2(NUM_REQUESTER) : 1;
  localparam int TW   = $clog2(TIMING_OUT_CYCLE + 1);
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMING_OUT_CYCLE);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [W-1:0]            r_cache_pkt;
  logic [NUM_REQUESTER-1:0] r_req_ack;
  logic [IDXW-1:0]         r_last_grant;
  logic [TW-1:0]           r_timer;
  logic [TW-1:0]           w_timer_nxt;
  logic                    r_error;

  logic [NUM_REQUESTER-1:0] w_req_valid;
  logic                    w_found;
  logic [IDXW-1:0]         w_winner;
  logic [IDXW-1:0]         w_cand;
  logic [W-1:0]            w_grant_pkt;
  logic [NUM_REQUESTER-1:0] w_grant_onehot;
  logic                    w_grant;
  logic                    w_timeout_hit;

  logic                    w_ret_valid;
  logic [P-1:0]            w_ret_port;
  logic [IDXW-1:0]         w_ret_sel;
  logic                    w_ret_in_range;
  logic [NUM_REQUESTER*W-1:0] w_ret_slots;
  logic                    w_ret_ack;
  logic                    w_ret_bad;

  // Extract the valid bit of every requester slot.
  always_comb begin
    w_req_valid = '0;
    for (int i = 0; i < NUM_REQUESTER; i++) begin
      w_req_valid[i] = io_bus.request_packet_flatted_in[i*W + VP];
    end
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_last_grant;
    w_cand   = r_last_grant;
    for (int k = 1; k <= NUM_REQUESTER; k++) begin
      w_cand = ((int'(r_last_grant) + k) >= NUM_REQUESTER) ?
               IDXW'(int'(r_last_grant) + k - NUM_REQUESTER) :
               IDXW'(int'(r_last_grant) + k);
      if (!w_found && w_req_valid[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end else begin
        w_found  = w_found;
      end
    end
  end

  // Winner packet with its port-number field rewritten to the winner index.
  always_comb begin
    w_grant_pkt            = io_bus.request_packet_flatted_in[w_winner*W +: W];
    w_grant_pkt[PHI:PLO]   = P'(w_winner);
    w_grant_onehot         = '0;
    w_grant_onehot[w_winner] = 1'b1;
  end

  // Request FSM next-state, grant strobe and ack-timeout counter.
  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_grant       = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_HOLD;
          w_grant     = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (io_bus.cache_packet_ack_in) begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = '0;
        end else begin
          // Counter saturates; the packet is never dropped on timeout.
          if (r_timer != TIMEOUT_VAL) begin
            w_timer_nxt = r_timer + TW'(1);
          end else begin
            w_timer_nxt = r_timer;
          end
          w_timeout_hit = (w_timer_nxt == TIMEOUT_VAL);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end

  // Combinational return steering by the packet's port-number field.
  always_comb begin
    w_ret_valid    = io_bus.cache_return_packet_in[VP];
    w_ret_port     = io_bus.cache_return_packet_in[PHI:PLO];
    w_ret_sel      = IDXW'(w_ret_port);
    w_ret_in_range = (int'(w_ret_port) < NUM_REQUESTER);
    w_ret_slots    = '0;
    w_ret_ack      = 1'b0;
    w_ret_bad      = 1'b0;
    if (w_ret_valid) begin
      if (w_ret_in_range) begin
        w_ret_slots[w_ret_sel*W +: W] = io_bus.cache_return_packet_in;
        w_ret_ack = io_bus.return_packet_ack_flatted_in[w_ret_sel];
      end else begin
        // Unroutable return: swallow it and flag an error.
        w_ret_ack = 1'b1;
        w_ret_bad = 1'b1;
      end
    end else begin
      w_ret_ack = 1'b0;
    end
  end

  // State, registered cache packet, ack pulse, last grant and sticky error.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_state      <= ST_IDLE;
      r_cache_pkt  <= '0;
      r_req_ack    <= '0;
      r_last_grant <= IDXW'(NUM_REQUESTER - 1);
      r_timer      <= '0;
      r_error      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_error <= r_error | w_timeout_hit | w_ret_bad;
      if (w_grant) begin
        r_cache_pkt  <= w_grant_pkt;
        r_req_ack    <= w_grant_onehot;
        r_last_grant <= w_winner;
      end else if ((r_state == ST_HOLD) && io_bus.cache_packet_ack_in) begin
        r_cache_pkt  <= '0;
        r_req_ack    <= '0;
      end else begin
        r_req_ack    <= '0;
      end
    end
  end

  assign io_bus.cache_packet_out               = r_cache_pkt;
  assign io_bus.request_packet_ack_flatted_out = r_req_ack;
  assign io_bus.error_out                      = r_error;
  assign io_bus.return_packet_flatted_out      = w_ret_slots;
  assign io_bus.cache_return_packet_ack_out    = w_ret_ack;

endmodule

// File: tb/tb_unified_cache_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_unified_cache_port_arbiter
// Self-checking bench for unified_cache_port_arbiter: directed scenarios plus
// randomized traffic compared against a behavioural reference model.
// -----------------------------------------------------------------------------
`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS 16
`endif
`ifndef UNIFIED_CACHE_PACKET_PORT_ID_WIDTH
`define UNIFIED_CACHE_PACKET_PORT_ID_WIDTH 3
`endif
`ifndef UNIFIED_CACHE_PACKET_VALID_POS
`define UNIFIED_CACHE_PACKET_VALID_POS 0
`endif
`ifndef UNIFIED_CACHE_PACKET_PORT_NUM_LO
`define UNIFIED_CACHE_PACKET_PORT_NUM_LO 1
`endif

module tb_unified_cache_port_arbiter;
  localparam int N  = 4;
  localparam int T  = 16;
  localparam int W  = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
  localparam int P  = `UNIFIED_CACHE_PACKET_PORT_ID_WIDTH;
  localparam int VP = `UNIFIED_CACHE_PACKET_VALID_POS;
  localparam int PL = `UNIFIED_CACHE_PACKET_PORT_NUM_LO;

  logic clk_in = 1'b0;
  logic reset_in = 1'b0;
  always #5 clk_in = ~clk_in;

  unified_cache_port_arbiter_if #(.NUM_REQUESTER(N), .PACKET_WIDTH(W)) bus ();

  unified_cache_port_arbiter #(
    .NUM_REQUESTER(N),
    .TIMING_OUT_CYCLE(T),
    .UNIFIED_CACHE_PACKET_WIDTH_IN_BITS(W),
    .UNIFIED_CACHE_PACKET_PORT_ID_WIDTH(P)
  ) dut (
    .clk_in(clk_in),
    .reset_in(reset_in),
    .io_bus(bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // reference model state
  logic         m_hold;
  logic [W-1:0] m_pkt;
  logic [N-1:0] m_ack;
  int           m_last;
  int           m_cnt;
  logic         m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_pkt(input logic [W-1:0] payload, input int port, input logic vld);
    logic [W-1:0] p;
    p = payload;
    p[VP] = vld;
    p[PL +: P] = P'(port);
    return p;
  endfunction

  task automatic model_reset();
    m_hold = 1'b0;
    m_pkt  = '0;
    m_ack  = '0;
    m_last = N - 1;
    m_cnt  = 0;
    m_err  = 1'b0;
  endtask

  task automatic check_outputs();
    logic [N*W-1:0] e_slots;
    logic           e_rack;
    logic [W-1:0]   r;
    int             idx;
    chk("cache_pkt", bus.cache_packet_out, m_pkt);
    chk("req_ack", bus.request_packet_ack_flatted_out, m_ack);
    chk("error", bus.error_out, m_err);
    e_slots = '0;
    e_rack  = 1'b0;
    r = bus.cache_return_packet_in;
    if (r[VP]) begin
      idx = int'(r[PL +: P]);
      if (idx < N) begin
        e_slots[idx*W +: W] = r;
        e_rack = bus.return_packet_ack_flatted_in[idx];
      end else begin
        e_rack = 1'b1;
      end
    end
    chk("ret_slots", bus.return_packet_flatted_out, e_slots);
    chk("ret_ack", bus.cache_return_packet_ack_out, e_rack);
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic model_update();
    logic [N*W-1:0] req;
    logic [W-1:0]   r;
    int             c;
    int             win;
    req = bus.request_packet_flatted_in;
    r   = bus.cache_return_packet_in;
    if (!m_hold) begin
      win = -1;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (win < 0 && req[c*W + VP]) win = c;
      end
      m_ack = '0;
      if (win >= 0) begin
        m_pkt = req[win*W +: W];
        m_pkt[PL +: P] = P'(win);
        m_ack[win] = 1'b1;
        m_last = win;
        m_hold = 1'b1;
      end
    end else begin
      m_ack = '0;
      if (bus.cache_packet_ack_in) begin
        m_pkt  = '0;
        m_hold = 1'b0;
        m_cnt  = 0;
      end else begin
        if (m_cnt < T) m_cnt++;
        if (m_cnt >= T) m_err = 1'b1;
      end
    end
    if (r[VP] && int'(r[PL +: P]) >= N) m_err = 1'b1;
  endtask

  // Called at a falling edge after inputs are driven.
  task automatic step();
    #1;
    check_outputs();
    model_update();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic clear_inputs();
    bus.request_packet_flatted_in    = '0;
    bus.cache_packet_ack_in          = 1'b0;
    bus.cache_return_packet_in       = '0;
    bus.return_packet_ack_flatted_in = '0;
  endtask

  task automatic apply_reset();
    reset_in = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk_in);
    @(negedge clk_in);
    reset_in = 1'b1;
  endtask

  initial begin
    logic [W-1:0] pay;
    logic [W-1:0] exp_pkt;
    logic [W-1:0] rp;
    int g;
    int idx;

    clear_inputs();
    @(negedge clk_in);
    apply_reset();

    // requester 2 alone
    bus.request_packet_flatted_in[2*W +: W] = mk_pkt(16'hA5A0, 7, 1'b1);
    step();
    bus.request_packet_flatted_in = '0;
    chk("t1_port", bus.cache_packet_out[PL +: P], 64'd2);
    chk("t1_ackvec", bus.request_packet_ack_flatted_out, 64'h4);
    chk("t1_pkt", bus.cache_packet_out, mk_pkt(16'hA5A0, 2, 1'b1));
    step();
    chk("t1_ack_once", bus.request_packet_ack_flatted_out, 64'h0);
    bus.cache_packet_ack_in = 1'b1;
    step();
    bus.cache_packet_ack_in = 1'b0;
    chk("t1_clear", bus.cache_packet_out, 64'h0);
    step();

    // all requesters valid, cache acks immediately
    apply_reset();
    g = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      for (int i = 0; i < N; i++)
        bus.request_packet_flatted_in[i*W +: W] = mk_pkt(W'($urandom), i, 1'b1);
      bus.cache_packet_ack_in = 1'b1;
      if (bus.request_packet_ack_flatted_out != '0) begin
        idx = -1;
        for (int b = 0; b < N; b++) if (bus.request_packet_ack_flatted_out[b]) idx = b;
        chk("t2_order", idx, g % N);
        g++;
      end
      step();
    end
    chk("t2_grants", g, 64'd8);
    clear_inputs();
    step();
    step();

    // cache never acks: timeout
    apply_reset();
    pay = W'($urandom);
    bus.request_packet_flatted_in[1*W +: W] = mk_pkt(pay, 6, 1'b1);
    exp_pkt = mk_pkt(pay, 1, 1'b1);
    step();
    bus.request_packet_flatted_in = '0;
    for (int k = 1; k <= 20; k++) begin
      chk("t3_pkt", bus.cache_packet_out, exp_pkt);
      chk("t3_err", bus.error_out, 64'(k >= T + 1));
      step();
    end
    bus.cache_packet_ack_in = 1'b1;
    step();
    bus.cache_packet_ack_in = 1'b0;
    step();

    // return steering, in-range and out-of-range
    apply_reset();
    rp = mk_pkt(16'h3C30, 1, 1'b1);
    bus.cache_return_packet_in = rp;
    bus.return_packet_ack_flatted_in = 4'b0010;
    #1;
    chk("t4_slot1", bus.return_packet_flatted_out[1*W +: W], rp);
    chk("t4_slots", bus.return_packet_flatted_out, {32'h0, rp, 16'h0});
    chk("t4_rack1", bus.cache_return_packet_ack_out, 64'd1);
    bus.return_packet_ack_flatted_in = 4'b1101;
    #1;
    chk("t4_rack0", bus.cache_return_packet_ack_out, 64'd0);
    step();
    bus.cache_return_packet_in = mk_pkt(16'h7770, 5, 1'b1);
    bus.return_packet_ack_flatted_in = 4'b0000;
    #1;
    chk("t5_slots", bus.return_packet_flatted_out, 64'h0);
    chk("t5_rack", bus.cache_return_packet_ack_out, 64'd1);
    chk("t5_err_before", bus.error_out, 64'd0);
    step();
    bus.cache_return_packet_in = '0;
    chk("t5_err_after", bus.error_out, 64'd1);
    step();

    // reset in the middle of HOLD
    apply_reset();
    bus.request_packet_flatted_in[3*W +: W] = mk_pkt(16'h1230, 0, 1'b1);
    step();
    bus.request_packet_flatted_in = '0;
    step();
    reset_in = 1'b0;
    #1;
    chk("t6_async_clear", bus.cache_packet_out, 64'h0);
    model_reset();
    @(posedge clk_in);
    @(negedge clk_in);
    reset_in = 1'b1;
    for (int i = 0; i < N; i++)
      bus.request_packet_flatted_in[i*W +: W] = mk_pkt(W'($urandom), 3, 1'b1);
    step();
    bus.request_packet_flatted_in = '0;
    chk("t6_port0", bus.cache_packet_out[PL +: P], 64'd0);
    chk("t6_ack0", bus.request_packet_ack_flatted_out, 64'h1);
    bus.cache_packet_ack_in = 1'b1;
    step();
    bus.cache_packet_ack_in = 1'b0;

    // randomized traffic
    apply_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int i = 0; i < N; i++)
        bus.request_packet_flatted_in[i*W +: W] =
          mk_pkt(W'($urandom), $urandom_range(7, 0), 1'($urandom_range(1, 0)));
      bus.cache_packet_ack_in = ($urandom_range(2, 0) == 0);
      bus.cache_return_packet_in =
        mk_pkt(W'($urandom),
               ($urandom_range(7, 0) == 0) ? $urandom_range(7, 4) : $urandom_range(3, 0),
               1'($urandom_range(1, 0)));
      bus.return_packet_ack_flatted_in = N'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
